morty_pipe_stage: RTL and testbench

Parametrised pipeline stage register for the Morty core. It is the generalised replacement for the fixed, field-by-field inter-stage registers. It carries one opaque DATA_W-bit payload bundle per stage boundary. It adds a valid/ready handshake, flush-to-bubble and an optional skid entry, so that back-pressure does not form a combinational path through the pipeline.

---
 rtl/morty_pipe_stage.sv | 123 ++++++++++++
 tb/tb_morty_pipe_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/morty_pipe_stage.sv
// rtl/morty_pipe_stage.sv - valid/ready pipeline stage register with flush and optional skid entry
// Optional feature: define MORTY_PIPE_SKID_EN to build the skid entry (registered in_ready, occupancy up to 2).
module morty_pipe_stage #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_VALUE = DATA_W'(32'h0000_0033)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // State encoding doubles as the entry count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef MORTY_PIPE_SKID_EN
    localparam logic [1:0] ST_SKID  = 2'd2;
`endif

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic              out_valid_q, out_valid_d;
    logic              in_xfer;
    logic              out_xfer;

`ifdef MORTY_PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;
`else
    // Without a skid entry a full stage can only accept when it drains in the same edge.
    assign in_ready = ~out_valid_q | out_ready;
`endif

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef MORTY_PIPE_SKID_EN
        skid_d  = skid_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_FULL;
                    main_d  = in_data;
                end
            end
            ST_FULL: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
`ifdef MORTY_PIPE_SKID_EN
                end else if (in_xfer) begin
                    state_d = ST_SKID;
                    skid_d  = in_data;
`endif
                end
            end
`ifdef MORTY_PIPE_SKID_EN
            ST_SKID: begin
                if (out_ready) begin
                    state_d = ST_FULL;
                    main_d  = skid_q;
                    skid_d  = NOP_VALUE;
                end
            end
`endif
            default: begin
                state_d = ST_EMPTY;
                main_d  = NOP_VALUE;
            end
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
`ifdef MORTY_PIPE_SKID_EN
            skid_d  = NOP_VALUE;
`endif
        end

        out_valid_d = (state_d != ST_EMPTY);
`ifdef MORTY_PIPE_SKID_EN
        in_ready_d  = (state_d != ST_SKID);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= NOP_VALUE;
            out_valid_q <= 1'b0;
`ifdef MORTY_PIPE_SKID_EN
            skid_q      <= NOP_VALUE;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= out_valid_d;
`ifdef MORTY_PIPE_SKID_EN
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

endmodule

// File: tb/tb_morty_pipe_stage.sv
// tb/tb_morty_pipe_stage.sv - directed scoreboard bench for morty_pipe_stage
module tb_morty_pipe_stage;

    localparam logic [31:0] NOP = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    morty_pipe_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; the scoreboard judges transfers at the falling edge, before the rising edge commits them.
    task automatic step(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        if (rst) begin
            if (!out_valid) check("bubble_nop", out_data, NOP);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_extra", 32'(out_valid), 32'd0);
                else                check("sb_data", out_data, sb.pop_front());
            end
        end
        if (!rst || flush)          sb.delete();
        else if (in_valid && in_ready) sb.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset held with a valid input pending.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hAAAA_AAAA, 1'b1, 1'b0);
        rst = 1'b1;
        in_valid = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, NOP);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming, one payload per cycle.
        step(1'b1, 32'h1, 1'b1, 1'b0);
        check("stream_d1", out_data, 32'h1);
        check("stream_v1", 32'(out_valid), 32'd1);
        step(1'b1, 32'h2, 1'b1, 1'b0);
        check("stream_d2", out_data, 32'h2);
        step(1'b1, 32'h3, 1'b1, 1'b0);
        check("stream_d3", out_data, 32'h3);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream_drained", 32'(out_valid), 32'd0);
        check("stream_drained_nop", out_data, NOP);

`ifdef MORTY_PIPE_SKID_EN
        step(1'b1, 32'h10, 1'b0, 1'b0);
        check("bp_occ1", 32'(occupancy), 32'd1);
        step(1'b1, 32'h11, 1'b0, 1'b0);
        check("bp_occ2", 32'(occupancy), 32'd2);
        check("bp_in_ready0", 32'(in_ready), 32'd0);
        check("bp_hold10", out_data, 32'h10);
        step(1'b1, 32'h12, 1'b0, 1'b0);
        check("bp_still_occ2", 32'(occupancy), 32'd2);
        check("bp_still_hold10", out_data, 32'h10);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp_in_ready1", 32'(in_ready), 32'd1);
        check("bp_next11", out_data, 32'h11);
        check("bp_occ_back1", 32'(occupancy), 32'd1);
        idle(2);
        check("bp_empty", 32'(occupancy), 32'd0);

        step(1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b1, 32'h41, 1'b0, 1'b0);
        check("fl_pre_occ2", 32'(occupancy), 32'd2);
`else
        step(1'b1, 32'h10, 1'b0, 1'b0);
        check("bp_occ1", 32'(occupancy), 32'd1);
        check("bp_in_ready0", 32'(in_ready), 32'd0);
        step(1'b1, 32'h20, 1'b1, 1'b0);
        check("bp_both_xfer", out_data, 32'h20);
        check("bp_occ_still1", 32'(occupancy), 32'd1);
        idle(1);
        check("bp_empty", 32'(occupancy), 32'd0);

        step(1'b1, 32'h40, 1'b0, 1'b0);
        check("fl_pre_occ1", 32'(occupancy), 32'd1);
`endif
        // Flush with an input pending; 0x55 must never surface.
        step(1'b1, 32'h55, 1'b0, 1'b1);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_out_data", out_data, NOP);
        check("fl_occupancy", 32'(occupancy), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_no_55", 32'(out_valid), 32'd0);
        idle(2);

        // Flush alongside an output transfer: 0x60 delivered, 0x61 dropped.
        step(1'b1, 32'h60, 1'b1, 1'b0);
        step(1'b1, 32'h61, 1'b1, 1'b1);
        check("fl_out_xfer_empty", 32'(out_valid), 32'd0);
        idle(2);

        // Reset mid-operation drops the held payload.
        step(1'b1, 32'h77, 1'b0, 1'b0);
        check("mid_full77", out_data, 32'h77);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", out_data, NOP);
        check("mid_rst_occ", 32'(occupancy), 32'd0);
        idle(3);
        check("mid_no_77", 32'(out_valid), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
